// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles the requester-side and SDRAM-controller-side signals of
//   ram_arbiter.
//   Requester side : v_req/v_addr/v_ack (video), c_req/c_we/c_addr/c_di/c_ack
//                    (CPU), d_req/d_addr/d_di/d_ack (download), q (read data)
//   Controller side: m_req/m_we/m_addr/m_di out, m_q/m_ack in
//   Status         : owner (0 none, 1 video, 2 cpu, 3 download), err
//   Modports: master = arbiter view, slave = surrounding glue/controller view.
interface ram_arbiter_if #(
   parameter int unsigned AW = 23,
   parameter int unsigned DW = 8
);
   logic          v_req;
   logic [AW-1:0] v_addr;
   logic          v_ack;

   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_di;
   logic          c_ack;

   logic          d_req;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_di;
   logic          d_ack;

   logic [DW-1:0] q;

   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_di;
   logic [DW-1:0] m_q;
   logic          m_ack;

   logic [1:0]    owner;
   logic          err;

   modport master (
      input  v_req, v_addr, c_req, c_we, c_addr, c_di, d_req, d_addr, d_di,
      input  m_q, m_ack,
      output v_ack, c_ack, d_ack, q,
      output m_req, m_we, m_addr, m_di,
      output owner, err
   );

   modport slave (
      output v_req, v_addr, c_req, c_we, c_addr, c_di, d_req, d_addr, d_di,
      output m_q, m_ack,
      input  v_ack, c_ack, d_ack, q,
      input  m_req, m_we, m_addr, m_di,
      input  owner, err
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one SDRAM controller port between video fetch, Z80 CPU and the
//   download loader. Video has strict priority; CPU and download alternate
//   round-robin. One transfer at a time: IDLE -> GRANT -> DONE -> IDLE.
// Ports
//   clock : system clock
//   power : asynchronous active-low reset
//   bus   : ram_arbiter_if.master (requester handshakes, q, m_* controller
//           side, owner, err)
// Optional feature
//   ARB_TIMEOUT_EN : when defined, a GRANT lasting TIMEOUT cycles without
//                    m_ack is aborted (m_req dropped, err and owner's ack
//                    pulsed, q untouched). Undefined: GRANT waits forever and
//                    err is tied 0.
module ram_arbiter #(
   parameter int unsigned AW      = 23,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input logic           clock,
   input logic           power,
   ram_arbiter_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_VIDEO = 2'd1,
      OWN_CPU   = 2'd2,
      OWN_DL    = 2'd3
   } owner_t;

   // The abort compares against TIMEOUT-1, so anything below 2 is meaningless.
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("ram_arbiter: TIMEOUT must be at least 2");
   end

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   logic          rr_q, rr_d;          // 0: CPU next in line, 1: download
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_di_q, m_di_d;
   logic [DW-1:0] q_q, q_d;
   logic          v_ack_q, v_ack_d;
   logic          c_ack_q, c_ack_d;
   logic          d_ack_q, d_ack_d;
   logic          ack_owner;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_di_d    = m_di_q;
      q_d       = q_q;
      v_ack_d   = 1'b0;
      c_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      ack_owner = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (bus.v_req) begin
               owner_d  = OWN_VIDEO;
               m_we_d   = 1'b0;
               m_addr_d = bus.v_addr;
               m_req_d  = 1'b1;
               state_d  = S_GRANT;
            end else if (bus.c_req && (!bus.d_req || !rr_q)) begin
               owner_d  = OWN_CPU;
               m_we_d   = bus.c_we;
               m_addr_d = bus.c_addr;
               m_di_d   = bus.c_di;
               m_req_d  = 1'b1;
               rr_d     = 1'b1;
               state_d  = S_GRANT;
            end else if (bus.d_req) begin
               owner_d  = OWN_DL;
               m_we_d   = 1'b1;
               m_addr_d = bus.d_addr;
               m_di_d   = bus.d_di;
               m_req_d  = 1'b1;
               rr_d     = 1'b0;
               state_d  = S_GRANT;
            end
         end

         S_GRANT: begin
            if (bus.m_ack) begin
               m_req_d   = 1'b0;
               if (!m_we_q) q_d = bus.m_q;
               ack_owner = 1'b1;
               state_d   = S_DONE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Abort skips DONE: ack and err pulse while already in IDLE.
               m_req_d   = 1'b0;
               err_d     = 1'b1;
               ack_owner = 1'b1;
               owner_d   = OWN_NONE;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         S_DONE: begin
            owner_d = OWN_NONE;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      if (ack_owner) begin
         case (owner_q)
            OWN_VIDEO: v_ack_d = 1'b1;
            OWN_CPU:   c_ack_d = 1'b1;
            OWN_DL:    d_ack_d = 1'b1;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge power) begin
      if (!power) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_NONE;
         rr_q     <= 1'b0;
         m_req_q  <= 1'b0;
         m_we_q   <= 1'b0;
         m_addr_q <= '0;
         m_di_q   <= '0;
         q_q      <= '0;
         v_ack_q  <= 1'b0;
         c_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         m_req_q  <= m_req_d;
         m_we_q   <= m_we_d;
         m_addr_q <= m_addr_d;
         m_di_q   <= m_di_d;
         q_q      <= q_d;
         v_ack_q  <= v_ack_d;
         c_ack_q  <= c_ack_d;
         d_ack_q  <= d_ack_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clock or negedge power) begin
      if (!power) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.v_ack  = v_ack_q;
   assign bus.c_ack  = c_ack_q;
   assign bus.d_ack  = d_ack_q;
   assign bus.q      = q_q;
   assign bus.m_req  = m_req_q;
   assign bus.m_we   = m_we_q;
   assign bus.m_addr = m_addr_q;
   assign bus.m_di   = m_di_q;
   assign bus.owner  = owner_q;

endmodule
